// File: rtl/axi2apb_rd_burst.sv
// axi2apb_rd_burst
// Watches APB read transfers driven by an upstream AXI-to-APB bridge,
// captures each returned beat, and queues it as an AXI R-channel response.
// Each 32-bit APB word goes into the RDATA lane that the beat address selects.
// Lane selection treats the AXI data width as a multiple of 32 bits. The
// legal widths are 32, 64, 128 and 256. The FIFO depth must be a power of two
// and at least 2.
//
// Ports
//   clk, rst            : single clock, synchronous active-high reset
//   psel/penable/pwrite : APB bus observation (pwrite transfers are ignored)
//   pready/pslverr      : APB completion and slave error
//   prdata              : APB read data (32 bits)
//   cmd_start           : one-cycle pulse that starts a new read burst
//   cmd_len             : beats-1 of the current burst
//   cmd_id              : AXI ID of the current burst
//   cmd_addr            : current beat address (picks the RDATA lane)
//   cmd_err             : the current beat is a decode/slave error
//   rd_stall            : upstream must not start a new APB read setup phase
//   finish_rd           : pulses when the last beat of a burst is accepted on R
//   ovf_err             : sticky, set when a captured beat was dropped
//   RID..RVALID, RREADY : AXI R channel
module axi2apb_rd_burst #(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [31:0]               prdata,
  input  logic                      cmd_start,
  input  logic [7:0]                cmd_len,
  input  logic [AXI_ID_WIDTH-1:0]   cmd_id,
  input  logic [APB_ADDR_WIDTH+3:0] cmd_addr,
  input  logic                      cmd_err,
  output logic                      rd_stall,
  output logic                      finish_rd,
  output logic                      ovf_err,
  output logic [AXI_ID_WIDTH-1:0]   RID,
  output logic [AXI_DATA_WIDTH-1:0] RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY
);

  localparam int LANES = AXI_DATA_WIDTH / 32;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1C = CNT_W'(FIFO_DEPTH - 1);

  logic                      capture;
  logic                      push;
  logic                      pop;
  logic [AXI_DATA_WIDTH-1:0] wr_data;
  logic [1:0]                wr_resp;
  logic                      wr_last;
  logic [7:0]                cur_beat;
  logic [7:0]                beat_cnt;
  logic [CNT_W-1:0]          count;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic                      unused_addr;

  logic [AXI_ID_WIDTH-1:0]   mem_id   [FIFO_DEPTH];
  logic [AXI_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [1:0]                mem_resp [FIFO_DEPTH];
  logic                      mem_last [FIFO_DEPTH];

  // Only the lane bits of cmd_addr matter here; the rest belong upstream.
  assign unused_addr = ^cmd_addr;

  assign capture = psel & penable & ~pwrite & pready;
  assign pop     = RVALID & RREADY;
  // A full FIFO can still take a beat when the head leaves in the same cycle.
  assign push    = capture & ((count < DEPTH_C) | pop);

  // Place the APB word in its lane and zero every other lane.
  generate
    if (LANES > 1) begin : g_lanes
      localparam int LANE_BITS = $clog2(LANES);
      logic [LANE_BITS-1:0] lane;
      assign lane = cmd_addr[2 +: LANE_BITS];
      always_comb begin
        wr_data = '0;
        wr_data[32*lane +: 32] = prdata;
      end
    end else begin : g_single_lane
      assign wr_data = prdata;
    end
  endgenerate

  // cmd_err is upstream's own decode failure and outranks the slave error.
  assign wr_resp = cmd_err ? 2'b10 : (pslverr ? 2'b11 : 2'b00);

  // A capture that coincides with cmd_start is beat 0 of the new burst.
  assign cur_beat = cmd_start ? 8'd0 : beat_cnt;
  assign wr_last  = (cur_beat == cmd_len);

  // Control state: pointers, occupancy, beat counter and the sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= 8'd0;
      ovf_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // A dropped beat leaves beat_cnt alone, so the burst position stays
      // aligned with what actually reached the R channel.
      if (push)           beat_cnt <= wr_last ? 8'd0 : cur_beat + 8'd1;
      else if (cmd_start) beat_cnt <= 8'd0;
      if (capture && !push) ovf_err <= 1'b1;
    end
  end

  // Entry storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]   <= cmd_id;
      mem_data[wr_ptr] <= wr_data;
      mem_resp[wr_ptr] <= wr_resp;
      mem_last[wr_ptr] <= wr_last;
    end
  end

  // Outputs come from the head entry only (no bypass), and they are forced
  // quiet while rst is high, even before the clearing edge arrives.
  assign RVALID    = ~rst & (count != '0);
  assign RID       = rst ? '0 : mem_id[rd_ptr];
  assign RDATA     = rst ? '0 : mem_data[rd_ptr];
  assign RRESP     = rst ? 2'b00 : mem_resp[rd_ptr];
  assign RLAST     = ~rst & (count != '0) & mem_last[rd_ptr];
  assign rd_stall  = ~rst & (count >= DEPTH_M1C);
  assign finish_rd = RVALID & RREADY & RLAST;

endmodule

// File: doc/axi2apb_rd_burst.md
AXI2APB_RD_BURST -- requirements
Module: axi2apb_rd_burst

Interface
REQ-001 SHALL have parameter AXI_ID_WIDTH, default 6, AXI ID width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, R data width; legal values are 32, 64, 128 and 256.
REQ-003 SHALL have parameter APB_ADDR_WIDTH, default 12, APB slave address span.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, R response buffer entries; power of 2, at least 2.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-007 SHALL have APB observe ports psel, penable, pwrite, pready and pslverr (inputs, 1 bit each) and prdata (input, 32 bits).
REQ-008 SHALL have port cmd_start, input, 1 bit, a one-cycle pulse that marks a new read burst.
REQ-009 SHALL have port cmd_len, input, 8 bits, beats-1 of the current burst, stable from cmd_start to the last beat.
REQ-010 SHALL have port cmd_id, input, AXI_ID_WIDTH bits, the burst ID.
REQ-011 SHALL have port cmd_addr, input, APB_ADDR_WIDTH+4 bits, the current beat address, updated by upstream for each beat.
REQ-012 SHALL have port cmd_err, input, 1 bit, marking the current beat as a decode/slave error.
REQ-013 SHALL have port rd_stall, output, 1 bit; while it is high, upstream SHALL NOT begin a new APB read setup phase.
REQ-014 SHALL have port finish_rd, output, 1 bit, pulsing when the last beat of a burst is accepted.
REQ-015 SHALL have port ovf_err, output, 1 bit, a sticky flag that a beat was dropped.
REQ-016 SHALL have R channel outputs RID (AXI_ID_WIDTH bits), RDATA (AXI_DATA_WIDTH bits), RRESP (2 bits), RLAST (1 bit) and RVALID (1 bit), plus input RREADY (1 bit).

Function
REQ-017 SHALL define capture = psel & penable & ~pwrite & pready.
REQ-018 SHALL define LANES = AXI_DATA_WIDTH/32 and lane = cmd_addr[2+log2(LANES)-1:2], with lane = 0 when LANES = 1.
REQ-019 On capture, the entry SHALL carry prdata in bits [32*lane +: 32], with all other RDATA bits zero.
REQ-020 On capture, entry RRESP SHALL be 2'b10 if cmd_err, else 2'b11 if pslverr, else 2'b00; cmd_err takes priority.
REQ-021 On capture, entry RID SHALL be cmd_id.
REQ-022 Beat counter beat_cnt (8 bits) SHALL be cleared on cmd_start and incremented on each accepted capture.
REQ-023 Entry RLAST SHALL equal (beat_cnt == cmd_len); after the last beat is captured, beat_cnt SHALL return to 0.
REQ-024 If cmd_start and capture occur in the same cycle, the capture SHALL be treated as beat 0 of the new burst, and beat_cnt SHALL become 1, or 0 if cmd_len = 0.
REQ-025 SHALL implement a FIFO of FIFO_DEPTH entries with a count register of log2(FIFO_DEPTH)+1 bits and wrapping read/write pointers.
REQ-026 Push SHALL be accepted when capture & (count < FIFO_DEPTH | pop); pop = RVALID & RREADY.
REQ-027 Capture while full and not popping SHALL drop the beat, set ovf_err, and leave beat_cnt unchanged.
REQ-028 Simultaneous push and pop SHALL leave count unchanged; this is legal when full and when holding 1 entry.
REQ-029 RVALID SHALL equal (count != 0); RID, RDATA, RRESP and RLAST SHALL present the head entry.
REQ-030 There SHALL be no bypass: a beat captured at edge N is visible on R no earlier than the cycle after edge N.
REQ-031 While RVALID = 1 and RREADY = 0, R outputs SHALL be held stable.
REQ-032 rd_stall SHALL equal (count >= FIFO_DEPTH-1), registered-free.
REQ-033 finish_rd SHALL be combinational RVALID & RREADY & RLAST.
REQ-034 A psel & penable & pwrite transfer SHALL have no effect.

Reset
REQ-035 While rst = 1 at a clock edge, count, pointers, beat_cnt and ovf_err SHALL clear to 0.
REQ-036 While rst = 1, RVALID, RLAST, finish_rd and rd_stall SHALL be 0; RID, RDATA and RRESP SHALL be 0.
REQ-037 Reset mid-burst SHALL discard all buffered beats; the first post-reset capture without cmd_start is beat 0.

Verification
REQ-038 64-bit, cmd_len = 0, cmd_addr = 0x004, prdata = 0xDEADBEEF, RREADY = 1 -> next cycle RVALID = 1, RDATA = 0xDEADBEEF_00000000, RRESP = 00, RLAST = 1, finish_rd = 1.
REQ-039 cmd_len = 3, 4 captures, RREADY = 0 -> count = 4, rd_stall = 1 after the 3rd capture, only the 4th entry has RLAST = 1; drain shows in-order data.
REQ-040 Full FIFO, RREADY = 0, extra capture -> beat dropped, ovf_err = 1 held until rst; with RREADY = 1 same case -> beat kept, count stays 4.
REQ-041 cmd_err = 1 with pslverr = 1 -> RRESP = 10; cmd_err = 0 with pslverr = 1 -> RRESP = 11.
REQ-042 rst asserted with 2 entries buffered mid-burst -> RVALID = 0 the next cycle; the next capture has RLAST = (cmd_len == 0).
REQ-043 AXI_DATA_WIDTH = 32 and 256 -> lane always 0, or lane = cmd_addr[4:2] respectively; unselected lanes read as zero.
